fpmag_req: RTL and testbench

Fixed-point magnitude sequencer for the CODEC2_ENCODE_2400 encoder. It computes |z| = sqrt(re² + im²) for one complex sample held in S-E-M 1-15-16 sign-magnitude format. It squares and sums the sample locally, then acts as the initiator of the start/done square-root handshake: it drives `startsqrt` and `x` into an external `fpsqrt` instance and consumes `donesqrt` and `sqrt`. It sits between the spectral front end and `estimate_amplitudes`, giving upstream logic a single start/done interface per magnitude.

---
 rtl/fpmag_pkg.sv | 21 ++
 rtl/fpmag_req_fpsq.sv | 22 ++
 rtl/fpmag_req.sv | 164 ++++++++++++++++
 tb/tb_fpmag_req.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fpmag_pkg.sv
// Shared constants and state encoding for the fixed-point magnitude sequencer.
// Words are sign-magnitude Q15.16 (1 sign, 15 integer, 16 fraction bits).
package fpmag_pkg;

  localparam int N = 32;
  localparam int Q = 16;

  localparam logic [N-1:0] NUMBER_ONE = 32'h0001_0000;
  localparam logic [N-1:0] MAX_POS    = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_SQUARE  = 3'd2,
    S_SUM     = 3'd3,
    S_REQ     = 3'd4,
    S_WAIT    = 3'd5,
    S_DONE    = 3'd6
  } state_t;

endpackage

// File: rtl/fpmag_req_fpsq.sv
// Combinational Q15.16 magnitude squarer. Keeps the Q15.16 part of the
// 62-bit product and saturates to the largest positive magnitude when any
// integer bit beyond the 15-bit range is set.
module fpsq
  import fpmag_pkg::*;
(
  input  logic [N-2:0] i_mag,
  output logic [N-2:0] o_sq,
  output logic         o_ovf
);

  // Product already shifted down by Q; the upper bits are the overflow field.
  logic [2*N-3-Q:0] w_prod_q;

  // Square, realign to Q15.16 and saturate on overflow.
  always_comb begin
    w_prod_q = (2*N-2-Q)'(({{(N-1){1'b0}}, i_mag} * {{(N-1){1'b0}}, i_mag}) >> Q);
    o_ovf    = |w_prod_q[2*N-3-Q:N-1];
    o_sq     = o_ovf ? MAX_POS[N-2:0] : w_prod_q[N-2:0];
  end

endmodule

// File: rtl/fpmag_req.sv
// Magnitude sequencer: |z| = sqrt(re^2 + im^2) for one sign-magnitude Q15.16
// sample, using an external fpsqrt through a startsqrt/donesqrt handshake.
// Optional macro FPMAG_TIMEOUT_EN adds a WAIT-state timeout that finishes the
// request with mag=0 and err=1 after TIMEOUT cycles without donesqrt.
//
// state   | meaning
// IDLE    | waiting for startmag
// CAPTURE | register magnitudes of re and im (signs dropped)
// SQUARE  | register both saturated squares
// SUM     | add squares, saturate; zero sum skips the square root
// REQ     | startsqrt pulse, radicand on x_sqrt
// WAIT    | waiting for donesqrt (or timeout)
// DONE    | donemag pulse, mag/ovf/err valid
module fpmag_req
  import fpmag_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         startmag,
  input  logic [N-1:0] re,
  input  logic [N-1:0] im,
  output logic         startsqrt,
  output logic [N-1:0] x_sqrt,
  input  logic [N-1:0] sqrt_in,
  input  logic         donesqrt,
  output logic [N-1:0] mag,
  output logic         donemag,
  output logic         ovf,
  output logic         err
);

  state_t       r_state;
  logic [N-2:0] r_re;
  logic [N-2:0] r_im;
  logic [N-2:0] r_sq_re;
  logic [N-2:0] r_sq_im;
  logic         r_ovf_int;
  logic [N-1:0] r_x;
  logic [N-1:0] r_mag;
  logic         r_ovf;

  logic [N-2:0] w_sq_re;
  logic [N-2:0] w_sq_im;
  logic         w_ovf_re;
  logic         w_ovf_im;
  logic [N-1:0] w_sum_raw;
  logic [N-1:0] w_sum;
  logic         w_sum_ovf;

`ifdef FPMAG_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
`endif

  fpsq u_sq_re (.i_mag(r_re), .o_sq(w_sq_re), .o_ovf(w_ovf_re));
  fpsq u_sq_im (.i_mag(r_im), .o_sq(w_sq_im), .o_ovf(w_ovf_im));

  // Unsigned sum of the squares; a carry into the sign bit saturates.
  always_comb begin
    w_sum_raw = {1'b0, r_sq_re} + {1'b0, r_sq_im};
    w_sum_ovf = w_sum_raw[N-1];
    w_sum     = w_sum_ovf ? MAX_POS : w_sum_raw;
  end

  // Sequencer state, datapath registers and held results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_re      <= '0;
      r_im      <= '0;
      r_sq_re   <= '0;
      r_sq_im   <= '0;
      r_ovf_int <= 1'b0;
      r_x       <= '0;
      r_mag     <= '0;
      r_ovf     <= 1'b0;
`ifdef FPMAG_TIMEOUT_EN
      r_cnt     <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (startmag) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          // Masking with MAX_POS drops the sign bit.
          r_re    <= (N-1)'(re & MAX_POS);
          r_im    <= (N-1)'(im & MAX_POS);
          r_state <= S_SQUARE;
        end
        S_SQUARE: begin
          r_sq_re   <= w_sq_re;
          r_sq_im   <= w_sq_im;
          r_ovf_int <= w_ovf_re | w_ovf_im;
          r_state   <= S_SUM;
        end
        S_SUM: begin
          r_x       <= w_sum;
          r_ovf_int <= r_ovf_int | w_sum_ovf;
          if (w_sum == '0) begin
            r_mag   <= '0;
            r_ovf   <= r_ovf_int | w_sum_ovf;
`ifdef FPMAG_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            r_state <= S_DONE;
          end else begin
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
`ifdef FPMAG_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (donesqrt) begin
            r_mag   <= sqrt_in;
            r_ovf   <= r_ovf_int;
`ifdef FPMAG_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            r_state <= S_DONE;
          end
`ifdef FPMAG_TIMEOUT_EN
          else if (r_cnt == TC_LAST) begin
            // The counter would reach TIMEOUT this edge: give up.
            r_mag   <= '0;
            r_ovf   <= r_ovf_int;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign startsqrt = (r_state == S_REQ);
  assign donemag   = (r_state == S_DONE);
  assign x_sqrt    = r_x;
  assign mag       = r_mag;
  assign ovf       = r_ovf;
`ifdef FPMAG_TIMEOUT_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fpmag_req.sv
// Directed bench for fpmag_req. Drives inputs 1 time unit after the rising
// edge and samples outputs on the falling edge. Cycle t is the cycle in which
// startmag is high.
module tb_fpmag_req;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startmag = 1'b0;
  logic [31:0] re = '0;
  logic [31:0] im = '0;
  logic        startsqrt;
  logic [31:0] x_sqrt;
  logic [31:0] sqrt_in = '0;
  logic        donesqrt = 1'b0;
  logic [31:0] mag;
  logic        donemag;
  logic        ovf;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  fpmag_req #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .startmag(startmag), .re(re), .im(im),
    .startsqrt(startsqrt), .x_sqrt(x_sqrt), .sqrt_in(sqrt_in),
    .donesqrt(donesqrt), .mag(mag), .donemag(donemag), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  // Present a request for one cycle; returns 1 unit into cycle t+1.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    re = a; im = b; startmag = 1'b1;
    @(posedge clk); #1;
    startmag = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    n_vec++;
    if ({startsqrt, donemag, ovf, err} !== 4'b0 || x_sqrt !== 32'h0 || mag !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got ss=%b dm=%b ovf=%b err=%b x=%h mag=%h exp all 0",
               startsqrt, donemag, ovf, err, x_sqrt, mag);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  // Full handshake; the model returns sq in cycle t+32 (28 cycles after REQ).
  task automatic run_mag(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sq, input logic [31:0] ex_x,
                         input logic ex_ovf);
    bit stray;
    do_start(a, b);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_vec++;
        if (donemag !== 1'b0) begin
          n_bad++; $display("FAIL %s donemag_pulse_len got %b exp 0", nm, donemag);
        end
      end
      if (k < 4) begin
        n_vec++;
        if (startsqrt !== 1'b0) begin
          n_bad++; $display("FAIL %s startsqrt_early k=%0d got %b exp 0", nm, k, startsqrt);
        end
      end else begin
        n_vec++;
        if (startsqrt !== 1'b1 || x_sqrt !== ex_x) begin
          n_bad++;
          $display("FAIL %s req got ss=%b x=%h exp ss=1 x=%h", nm, startsqrt, x_sqrt, ex_x);
        end
      end
    end
    stray = 1'b0;
    for (int k = 5; k <= 31; k++) begin
      @(negedge clk);
      if (startsqrt !== 1'b0 || donemag !== 1'b0 || x_sqrt !== ex_x) stray = 1'b1;
    end
    n_vec++;
    if (stray) begin
      n_bad++; $display("FAIL %s wait_quiet got activity/x change exp none", nm);
    end
    @(posedge clk); #1;
    donesqrt = 1'b1; sqrt_in = sq;
    @(posedge clk); #1;
    donesqrt = 1'b0; sqrt_in = 32'h0;
    @(negedge clk);
    n_vec++;
    if (donemag !== 1'b1 || mag !== sq || ovf !== ex_ovf || err !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done got dm=%b mag=%h ovf=%b err=%b exp dm=1 mag=%h ovf=%b err=0",
               nm, donemag, mag, ovf, err, sq, ex_ovf);
    end
  endtask

  task automatic test_zero;
    do_start(32'h0, 32'h8000_0000);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (startsqrt !== 1'b0 || donemag !== (k == 4) || (k == 4 && mag !== 32'h0)) begin
        n_bad++;
        $display("FAIL zero_path k=%0d got ss=%b dm=%b mag=%h exp ss=0 dm=%b mag=0",
                 k, startsqrt, donemag, mag, (k == 4));
      end
    end
  endtask

  task automatic test_rst_in_wait;
    bit stray;
    do_start(32'h0003_0000, 32'h0004_0000);
    repeat (7) @(negedge clk);
    @(posedge clk); #1 startmag = 1'b1;
    @(posedge clk); #1 startmag = 1'b0;
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (startsqrt !== 1'b0 || donemag !== 1'b0) stray = 1'b1;
    end
    n_vec++;
    if (stray) begin
      n_bad++; $display("FAIL startmag_in_wait got second request exp none");
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({startsqrt, donemag, ovf, err} !== 4'b0 || x_sqrt !== 32'h0 || mag !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_in_wait got ss=%b dm=%b ovf=%b err=%b x=%h mag=%h exp all 0",
               startsqrt, donemag, ovf, err, x_sqrt, mag);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 donesqrt = 1'b1; sqrt_in = 32'h0001_2345;
    @(posedge clk); #1 donesqrt = 1'b0; sqrt_in = 32'h0;
    stray = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (donemag !== 1'b0 || mag !== 32'h0 || startsqrt !== 1'b0) stray = 1'b1;
    end
    n_vec++;
    if (stray) begin
      n_bad++; $display("FAIL late_donesqrt got reaction exp ignored (mag=%h)", mag);
    end
  endtask

`ifdef FPMAG_TIMEOUT_EN
  task automatic test_timeout;
    bit stray;
    do_start(32'h0003_0000, 32'h0004_0000);
    stray = 1'b0;
    for (int k = 1; k <= 68; k++) begin
      @(negedge clk);
      if (donemag !== 1'b0) stray = 1'b1;
    end
    n_vec++;
    if (stray) begin
      n_bad++; $display("FAIL timeout_early got donemag before t+69 exp none");
    end
    @(negedge clk);
    n_vec++;
    if (donemag !== 1'b1 || err !== 1'b1 || mag !== 32'h0) begin
      n_bad++;
      $display("FAIL timeout_done got dm=%b err=%b mag=%h exp dm=1 err=1 mag=0",
               donemag, err, mag);
    end
  endtask
`else
  task automatic test_wait_hold;
    bit stray;
    do_start(32'h0003_0000, 32'h0004_0000);
    stray = 1'b0;
    repeat (104) begin
      @(negedge clk);
      if (donemag !== 1'b0 || err !== 1'b0) stray = 1'b1;
    end
    n_vec++;
    if (stray) begin
      n_bad++; $display("FAIL wait_hold got done/err without donesqrt exp hold");
    end
    @(posedge clk); #1 donesqrt = 1'b1; sqrt_in = 32'h0005_0000;
    @(posedge clk); #1 donesqrt = 1'b0; sqrt_in = 32'h0;
    @(negedge clk);
    n_vec++;
    if (donemag !== 1'b1 || mag !== 32'h0005_0000 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL wait_hold_done got dm=%b mag=%h err=%b exp dm=1 mag=00050000 err=0",
               donemag, mag, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    run_mag("basic",   32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 32'h0019_0000, 1'b0);
    run_mag("negative", 32'h8003_0000, 32'h8004_0000, 32'h0005_0000, 32'h0019_0000, 1'b0);
    run_mag("overflow", 32'h7FFF_0000, 32'h0001_0000, 32'h00B5_04F3, 32'h7FFF_FFFF, 1'b1);
    run_mag("after_ovf", 32'h0000_8000, 32'h0000_8000, 32'h0000_B505, 32'h0000_8000, 1'b0);
    test_zero();
    test_rst_in_wait();
    run_mag("after_rst", 32'h0006_0000, 32'h8008_0000, 32'h000A_0000, 32'h0064_0000, 1'b0);
`ifdef FPMAG_TIMEOUT_EN
    test_timeout();
    run_mag("after_timeout", 32'h0003_0000, 32'h0004_0000, 32'h0005_0000, 32'h0019_0000, 1'b0);
`else
    test_wait_hold();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
